// File: rtl/grf_mp.sv
// Multi-port general register file: two combinational reads, two prioritised
// writes, optional zero register and bypass, plus a valid/ready dump engine.
module grf_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    logic [DATA_W-1:0] regs_q [DEPTH];
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              wr0_en, wr1_en;
    logic [ADDR_W-1:0] ra   [2];
    logic [DATA_W-1:0] rd   [2];

    assign wr0_en = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    assign wr1_en = we1 && !((ZERO_REG != 0) && (wa1 == '0));

    // Port 1 is applied last so it wins a same-address conflict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr0_en) regs_q[wa0] <= wd0;
            if (wr1_en) regs_q[wa1] <= wd1;
        end
    end

    assign ra[0] = ra1;
    assign ra[1] = ra2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = regs_q[ra[p]];
            if ((ZERO_REG != 0) && (ra[p] == '0)) begin
                rd[p] = '0;
            end else if (BYPASS != 0) begin
                if (we1 && (wa1 == ra[p])) begin
                    rd[p] = wd1;
                end else if (we0 && (wa0 == ra[p])) begin
                    rd[p] = wd0;
                end
            end
        end
    end

    assign rd1 = rd[0];
    assign rd2 = rd[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (cnt_q == '1) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                dump_done = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dump_busy = (state_q != IDLE);
    assign dump_addr = cnt_q;
    assign dump_data = ((ZERO_REG != 0) && (cnt_q == '0)) ? '0 : regs_q[cnt_q];

endmodule

// File: tb/tb_grf_mp.sv
// Directed bench for grf_mp: default instance (zero reg, bypass) alongside a
// plain instance (no zero reg, no bypass) driven by the same stimulus.
module tb_grf_mp;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2, wa0, wa1;
    logic        we0, we1;
    logic [31:0] wd0, wd1;
    logic        dump_start, dump_ready;

    logic [31:0] rd1_a, rd2_a, dd_a, rd1_b, rd2_b, dd_b;
    logic        dv_a, db_a, dn_a, dv_b, db_b, dn_b;
    logic [4:0]  da_a, da_b;

    int checks = 0;
    int failures = 0;

    grf_mp u_a (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_a), .rd2(rd2_a),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .dump_start(dump_start), .dump_valid(dv_a), .dump_ready(dump_ready),
        .dump_addr(da_a), .dump_data(dd_a), .dump_busy(db_a), .dump_done(dn_a)
    );

    grf_mp #(.ZERO_REG(0), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_b), .rd2(rd2_b),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
        .dump_start(dump_start), .dump_valid(dv_b), .dump_ready(dump_ready),
        .dump_addr(da_b), .dump_data(dd_b), .dump_busy(db_b), .dump_done(dn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ea;
        int cyc;
        logic rdy;
        reset = 1'b0;
        ra1 = '0; ra2 = '0; wa0 = '0; wa1 = '0;
        we0 = 1'b0; we1 = 1'b0; wd0 = '0; wd1 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, dv_a}, 32'd0);
        chk("rst_busy", {31'd0, db_a}, 32'd0);
        chk("rst_done", {31'd0, dn_a}, 32'd0);
        chk("rst_addr", {27'd0, da_a}, 32'd0);
        reset = 1'b1;
        #1;

        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            ra2 = 5'(31 - i);
            #1;
            chk("init_rd1", rd1_a, 32'd0);
            chk("init_rd2", rd2_a, 32'd0);
            chk("init_rd1_b", rd1_b, 32'd0);
        end

        // single write, bypass vs. array
        we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
        #1;
        chk("wr_byp_a", rd1_a, 32'hDEADBEEF);
        chk("wr_nobyp_b", rd1_b, 32'd0);
        tick();
        we0 = 1'b0;
        #1;
        chk("wr_stored_a", rd1_a, 32'hDEADBEEF);
        chk("wr_stored_b", rd1_b, 32'hDEADBEEF);

        // same-address conflict
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h22;
        ra1 = 5'd3;
        #1;
        chk("conf_byp_a", rd1_a, 32'h22);
        chk("conf_old_b", rd1_b, 32'h0);
        tick();
        we0 = 1'b0; we1 = 1'b0;
        #1;
        chk("conf_st_a", rd1_a, 32'h22);
        chk("conf_st_b", rd1_b, 32'h22);

        // zero register
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; ra1 = 5'd0;
        #1;
        chk("zero_c0_a", rd1_a, 32'd0);
        chk("zero_c0_b", rd1_b, 32'd0);
        tick();
        we0 = 1'b0;
        #1;
        chk("zero_c1_a", rd1_a, 32'd0);
        chk("zero_c1_b", rd1_b, 32'hFFFFFFFF);

        // port-1 write, read on port 2
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h1234; ra2 = 5'd7;
        #1;
        chk("byp0_old_b", rd2_b, 32'd0);
        chk("byp1_new_a", rd2_a, 32'h1234);
        tick();
        we1 = 1'b0;
        #1;
        chk("byp0_new_b", rd2_b, 32'h1234);

        // fill reg[i] = i*0x10, two per cycle
        for (int k = 0; k < 16; k++) begin
            we0 = 1'b1; wa0 = 5'(2 * k);     wd0 = 32'(2 * k * 16);
            we1 = 1'b1; wa1 = 5'(2 * k + 1); wd1 = 32'((2 * k + 1) * 16);
            tick();
        end
        we0 = 1'b0; we1 = 1'b0;
        ra1 = 5'd31; ra2 = 5'd0;
        #1;
        chk("fill_31", rd1_a, 32'h1F0);
        chk("fill_0_b", rd2_b, 32'h0);

        // dump with ready high
        dump_ready = 1'b1;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 2) dump_start = 1'b1;
            if (i == 4) dump_start = 1'b0;
            chk("d1_valid", {31'd0, dv_a}, 32'd1);
            chk("d1_addr", {27'd0, da_a}, 32'(i));
            chk("d1_data", dd_a, 32'(i * 16));
            chk("d1_data_b", dd_b, 32'(i * 16));
            chk("d1_done", {31'd0, dn_a}, 32'd0);
            tick();
        end
        chk("d1_done_pulse", {31'd0, dn_a}, 32'd1);
        chk("d1_done_busy", {31'd0, db_a}, 32'd1);
        chk("d1_done_valid", {31'd0, dv_a}, 32'd0);
        tick();
        chk("d1_idle_done", {31'd0, dn_a}, 32'd0);
        chk("d1_idle_busy", {31'd0, db_a}, 32'd0);
        chk("d1_idle_addr", {27'd0, da_a}, 32'd0);

        // dump with ready toggling, reset while presenting addr 12
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        ea = 0;
        cyc = 0;
        while (ea < 12 && cyc < 100) begin
            rdy = (cyc % 2 == 0);
            dump_ready = rdy;
            chk("d2_valid", {31'd0, dv_a}, 32'd1);
            chk("d2_addr", {27'd0, da_a}, 32'(ea));
            chk("d2_data", dd_a, 32'(ea * 16));
            tick();
            if (rdy) ea++;
            cyc++;
        end
        chk("d2_reached12", 32'(ea), 32'd12);
        chk("d2_addr12", {27'd0, da_a}, 32'd12);
        reset = 1'b0;
        #1;
        chk("d2_rst_valid", {31'd0, dv_a}, 32'd0);
        chk("d2_rst_busy", {31'd0, db_a}, 32'd0);
        chk("d2_rst_addr", {27'd0, da_a}, 32'd0);
        ra1 = 5'd12; ra2 = 5'd31;
        #1;
        chk("d2_rst_reg12", rd1_a, 32'd0);
        chk("d2_rst_reg31", rd2_a, 32'd0);
        chk("d2_rst_reg12_b", rd1_b, 32'd0);
        tick();
        reset = 1'b1;
        dump_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("d2_no_done", {31'd0, dn_a}, 32'd0);
            chk("d2_no_busy", {31'd0, db_a}, 32'd0);
            tick();
        end
        ra1 = 5'd5;
        #1;
        chk("d2_reg5_clr", rd1_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
